// File: rtl/fifo_uart_tx_drain.sv
// Pops bytes from a 64x8 synchronous FIFO and serializes each one as a UART frame.
// Latency: fetch on the edge after an idle cycle sees enable & !fifo_empty; start bit 2 cycles later.
// Backpressure: only pops when enable=1 and fifo_empty=0 in IDLE; a frame in flight always completes.
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   enable            - permits new fetches (sampled in IDLE only)
//   fifo_empty        - FIFO empty flag
//   fifo_data[7:0]    - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en        - one-cycle pop strobe (FETCH state only)
//   tx                - serial line, idles high
//   busy              - high in every state except IDLE
//   byte_done         - one-cycle pulse in the last clock of the final stop bit
//   frame_cnt[15:0]   - completed frame count, wraps
//
// Frame: start(0), d0..d7, [parity], 1 or 2 stop bits(1); each bit lasts CLK_DIV clocks.
// All outputs are registered: every output's next value is computed alongside the next state,
// so tx switches on the same edge that enters the state driving it.

module fifo_uart_tx_drain #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        byte_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  // byte_done is registered, so it is requested one clock before the final stop clock.
  localparam logic [15:0] BAUD_PRE  = 16'(CLK_DIV - 2);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic        PAR_INV   = (PARITY_ODD != 0);
  localparam logic        HAS_PAR   = (PARITY_EN != 0);

  state_t      state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  bit_idx, bit_idx_n;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]  shreg, shreg_n;
  logic        par_bit, par_bit_n;
  logic        tx_n;
  logic        rd_en_n;
  logic        busy_n;
  logic        byte_done_n;
  logic [15:0] frame_cnt_n;

  logic baud_end;
  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_en_n;
      busy       <= busy_n;
      byte_done  <= byte_done_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    baud_n      = baud;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    par_bit_n   = par_bit;
    tx_n        = tx;
    rd_en_n     = 1'b0;
    byte_done_n = 1'b0;
    frame_cnt_n = frame_cnt;

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (enable && !fifo_empty) begin
          state_n = FETCH;
          rd_en_n = 1'b1;
        end
      end

      // Pop strobe is high during this cycle; the RAM answers in LOAD.
      FETCH: begin
        state_n = LOAD;
      end

      // fifo_data is valid now; capture it and precompute parity so later
      // shifting does not disturb it.
      LOAD: begin
        shreg_n   = fifo_data;
        par_bit_n = (^fifo_data) ^ PAR_INV;
        state_n   = START;
        tx_n      = 1'b0;
        baud_n    = '0;
      end

      START: begin
        if (baud_end) begin
          state_n   = DATA;
          tx_n      = shreg[0];
          baud_n    = '0;
          bit_idx_n = '0;
        end else begin
          baud_n = baud + 16'd1;
        end
      end

      // shreg[0] is the bit on the line; shifting right exposes the next one.
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            if (HAS_PAR) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end

      PARITY: begin
        if (baud_end) begin
          state_n   = STOP;
          tx_n      = 1'b1;
          baud_n    = '0;
          bit_idx_n = '0;
        end else begin
          baud_n = baud + 16'd1;
        end
      end

      STOP: begin
        tx_n        = 1'b1;
        byte_done_n = (bit_idx == STOP_LAST) && (baud == BAUD_PRE);
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == STOP_LAST) begin
            state_n     = IDLE;
            bit_idx_n   = '0;
            frame_cnt_n = frame_cnt + 16'd1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: three parameter sets driven by FIFO models and
// checked every cycle against an expected-waveform queue built from the framing rules.
// Inputs change on negedges; outputs are sampled on negedges.

module tb_fifo_uart_tx_drain;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs: {tx, rd_en, busy, byte_done}
  typedef struct packed {
    logic tx;
    logic rd;
    logic busy;
    logic bd;
  } ent_t;

  localparam ent_t IDLE_E = 4'b1000;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int CD = (g == 2) ? 2 : 4;
    localparam int PE = (g == 0) ? 0 : 1;
    localparam int PO = (g == 2) ? 1 : 0;
    localparam int SB = (g == 0) ? 1 : 2;

    logic        en = 1'b0;
    logic        emp = 1'b1;
    logic [7:0]  dat = 8'h00;
    logic        push_vld = 1'b0;
    logic [7:0]  push_dat = 8'h00;
    logic        tx, rd, busy, bd;
    logic [15:0] cnt;

    logic [7:0]  q[$];       // FIFO contents
    ent_t        eq[$];      // expected outputs for upcoming cycles
    ent_t        cur = IDLE_E;
    logic [15:0] cnt_m = 16'd0;

    fifo_uart_tx_drain #(
      .CLK_DIV(CD), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
    ) dut (
      .clk(clk), .rst(rst), .enable(en), .fifo_empty(emp), .fifo_data(dat),
      .fifo_rd_en(rd), .tx(tx), .busy(busy), .byte_done(bd), .frame_cnt(cnt)
    );

    // Waveform of one frame from the FETCH cycle to the last stop clock.
    task automatic build(input logic [7:0] d);
      logic bits[$];
      ent_t t;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (PE != 0) bits.push_back((PO != 0) ? ~^d : ^d);
      for (int s = 0; s < SB; s++) bits.push_back(1'b1);
      eq.push_back(4'b1110);   // FETCH
      eq.push_back(4'b1010);   // LOAD
      foreach (bits[b])
        for (int c = 0; c < CD; c++) eq.push_back({bits[b], 1'b0, 1'b1, 1'b0});
      t = eq.pop_back();
      t.bd = 1'b1;
      eq.push_back(t);
    endtask

    // Reference model plus FIFO model (registered read, flag updated at the edge).
    always @(posedge clk) begin
      if (rst) begin
        eq.delete();
        cur   <= IDLE_E;
        cnt_m <= 16'd0;
      end else begin
        if (cur.bd) cnt_m <= cnt_m + 16'd1;
        if (!cur.busy && en && !emp) build(q[0]);
        if (eq.size() != 0) cur <= eq.pop_front();
        else                cur <= IDLE_E;
        if (rd && q.size() != 0) dat <= q.pop_front();
      end
      if (push_vld) q.push_back(push_dat);
      emp <= (q.size() == 0);
    end

    always @(negedge clk) begin
      chk($sformatf("c%0d.tx", g),        32'(tx),   32'(cur.tx));
      chk($sformatf("c%0d.rd_en", g),     32'(rd),   32'(cur.rd));
      chk($sformatf("c%0d.busy", g),      32'(busy), 32'(cur.busy));
      chk($sformatf("c%0d.byte_done", g), 32'(bd),   32'(cur.bd));
      chk($sformatf("c%0d.frame_cnt", g), 32'(cnt),  32'(cnt_m));
    end

    task automatic push(input logic [7:0] b);
      @(negedge clk);
      push_vld = 1'b1;
      push_dat = b;
      @(negedge clk);
      push_vld = 1'b0;
    endtask

    initial begin
      en = 1'b1;
      push(8'hA5);                       // queued while reset is held
      repeat (60) @(negedge clk);
      push(8'hAA); push(8'hCC); push(8'hFF);
      repeat (250) @(negedge clk);
      push(8'h07);
      repeat (150) @(negedge clk);
      push(8'h3C); push(8'h96);          // first is cut by the mid-frame reset
      repeat (300) @(negedge clk);
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        en       = ($urandom_range(0, 99) < 85);
        push_vld = ($urandom_range(0, 39) == 0);
        push_dat = 8'($urandom);
      end
      push_vld = 1'b0;
      en = 1'b1;
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #3 rst = 1'b0;

    // Wait for the 0x3C fetch on config 0, then reset inside data bit 3.
    repeat (400) @(negedge clk);
    for (int k = 0; k < 300 && !g_cfg[0].rd; k++) @(negedge clk);
    chk("c0.rd_wait", 32'(g_cfg[0].rd), 32'd1);
    repeat (19) @(negedge clk);          // LOAD + START + d0..d2, then into d3
    chk("c0.busy_pre_rst", 32'(g_cfg[0].busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst.tx",        32'(g_cfg[0].tx),   32'd1);
    chk("rst.busy",      32'(g_cfg[0].busy), 32'd0);
    chk("rst.frame_cnt", 32'(g_cfg[0].cnt),  32'd0);
    chk("rst.rd_en",     32'(g_cfg[0].rd),   32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;

    repeat (1800) @(negedge clk);
    chk("c0.drained", 32'(g_cfg[0].busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx_drain.md
Name: fifo_uart_tx_drain

Overview:
Downstream consumer of the 64x8 synchronous FIFO. It pops bytes whenever the FIFO is non-empty and enabled, then serializes each byte onto a single UART-style line. Framing is start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It converts the FIFO's parallel burst output into a paced serial stream for the board-level transmit pin.

Parameters:
CLK_DIV, 16, clocks per serial bit; legal range 2..65535.
PARITY_EN, 0, 1 = insert parity bit after data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  permits new fetches; does not abort a frame in flight.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO read data; valid in the cycle after fifo_rd_en is high (registered RAM read).
fifo_rd_en  output  1  one-cycle pop strobe to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
byte_done  output  1  one-cycle pulse in the last clock of the final stop bit.
frame_cnt  output  16  count of completed frames; wraps 0xFFFF->0x0000.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async assert, takes effect immediately):
  - tx=1; fifo_rd_en=0; busy=0; byte_done=0; frame_cnt=0.
  - state=IDLE; bit counter and baud counter cleared.
  - Release is sampled at the next rising clk edge.
- All outputs are registered. tx changes on the same edge that enters a state.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0 at an edge, go to FETCH; otherwise stay.
- FETCH: exactly one cycle with fifo_rd_en=1; unconditionally go to LOAD.
- LOAD: one cycle. On exit, fifo_data is captured into an 8-bit shift register; go to START.
- START: tx=0 for CLK_DIV cycles.
- DATA: 8 bits, each held CLK_DIV cycles, bit 0 first; 3-bit index, 7->exit.
- PARITY: only if PARITY_EN=1. Holds CLK_DIV cycles.
  - Even parity: XOR of the 8 data bits.
  - Odd parity: the inverse of that.
- STOP:
  - tx=1 for STOP_BITS*CLK_DIV cycles.
  - byte_done=1 in the final cycle, and frame_cnt increments on that edge.
  - Then go to IDLE.
- Baud counter: counts 0..CLK_DIV-1, resets on every state/bit change, so each bit lasts exactly CLK_DIV clocks.
- Frame length from START entry to STOP exit: (9 + PARITY_EN + STOP_BITS)*CLK_DIV clocks.
- Back-to-back frames: IDLE, FETCH and LOAD each take one cycle. The tx-high gap between frames is therefore STOP_BITS*CLK_DIV + 3 clocks.
- Exactly one fifo_rd_en pulse per frame. Never asserted when fifo_empty=1 in the decision cycle, and never asserted outside FETCH.
- fifo_empty changing after FETCH has no effect on the frame in progress.
- enable=0 mid-frame: the current frame completes normally, then the block stays in IDLE.
- Reset mid-frame: the frame is abandoned and tx returns high at once. The popped byte is lost and is not re-fetched.

Test Plan:
1. rst=1 with fifo_empty=0 and enable=1 -> tx=1, fifo_rd_en=0, busy=0, frame_cnt=0 throughout reset. First fifo_rd_en appears 1 cycle after the first edge with rst=0.
2. CLK_DIV=4, no parity, 1 stop, one byte 0xA5 -> single fifo_rd_en pulse. tx shows 0,1,0,1,0,0,1,0,1,1, each for 4 clocks (40 clocks total). byte_done pulses once; frame_cnt=1; busy falls the cycle after.
3. Bytes 0xAA, 0xCC, 0xFF queued (fifo_empty low until the third pop), CLK_DIV=4 -> exactly 3 fifo_rd_en pulses. The tx-high gap between frames is 4+3=7 clocks. Data is correct LSB-first; frame_cnt=3.
4. PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0. STOP_BITS=2 -> tx high for 8 clocks before byte_done.
5. enable dropped during DATA of byte 1 with fifo_empty=0 -> byte 1 completes and frame_cnt increments. No further fifo_rd_en while enable=0; fetch resumes one cycle after enable returns high.
6. rst asserted during data bit 3 -> tx=1, busy=0, frame_cnt=0 immediately (before the next edge). After release with fifo_empty=0, a fresh FETCH occurs and the next byte transmits intact.
